cle_pixel_streamer: RTL and testbench
=====================================

Name: cle_pixel_streamer

Overview:
Upstream front end of the Component Labeling Engine. Fetches the packed 32x32 binary image from the 128x8 synchronous ROM and streams it as one pixel per cycle in raster order over a valid/ready handshake. Each pixel carries its (x,y) coordinates and its four causal neighbours (up-left, up, up-right, left), which the labeling core uses for its first-pass label decision.

Parameters:
IMG_W, 32, image width in pixels; power of 2, multiple of 8
IMG_H, 32, image height in pixels; IMG_W*IMG_H/8 must equal 2**ROM_AW
ROM_AW, 7, ROM address width
MSB_FIRST, 1, 1: rom byte bit7 is the leftmost pixel; 0: bit0 is the leftmost pixel

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin streaming an image; honoured only in IDLE
rom_a  out  ROM_AW  ROM address, registered
rom_q  in  8  ROM data, valid the cycle after rom_a is sampled
pix_valid  out  1  pixel outputs valid
pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready
pix_data  out  1  current pixel, 1 = foreground
pix_x  out  5  column, log2(IMG_W) bits
pix_y  out  5  row, log2(IMG_H) bits
nb_ul, nb_u, nb_ur, nb_l  out  1 each  neighbour pixels; 0 outside the image
pix_last  out  1  qualifies the pixel at (IMG_W-1, IMG_H-1)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset: state IDLE. rom_a=0; pix_valid, pix_data, pix_x, pix_y, all nb_*, pix_last, busy and done are 0. Line buffer cleared. Reset mid-stream aborts the frame with no done pulse.
- Byte mapping: ROM address a covers row a/(IMG_W/8) and columns (a mod (IMG_W/8))*8 to +7. Bit order follows MSB_FIRST.
- FSM states: IDLE, FETCH, STREAM, FLUSH.
  - IDLE: start=1 -> FETCH, rom_a<=0.
  - FETCH: wait one cycle for rom_q, capture it into the shift register, issue the next address -> STREAM.
  - STREAM: present pixels. After the final handshake -> FLUSH.
  - FLUSH: done=1 for one cycle -> IDLE.
- start is ignored while busy.
- Latency: if start is sampled at edge E0, pix_valid is high after edge E2.
- Prefetch: one next-byte register with a valid flag. The next address is issued while the current byte drains. With pix_ready held at 1, pix_valid is high for exactly IMG_W*IMG_H consecutive cycles (no bubbles at byte or row boundaries).
- Handshake: while pix_valid && !pix_ready, every pixel output holds stable. pix_valid never drops without a handshake, except on reset.
- rom_a advances by exactly 1 per byte and stops at 2**ROM_AW-1; it does not wrap during a frame.
- Neighbour generation uses an IMG_W-bit line buffer lb plus a one-bit register ul_save.
  - nb_u = lb[x] when y>0, else 0.
  - nb_ur = lb[x+1] when y>0 and x<IMG_W-1, else 0.
  - nb_ul = ul_save when y>0 and x>0, else 0.
  - nb_l = lb[x-1] when x>0, else 0. This is the current row, already written.
  - On each handshake: ul_save<=lb[x] (old value), then lb[x]<=pix_data.
- Coordinates: x wraps IMG_W-1 -> 0 with y+1. pix_last = (x==IMG_W-1 && y==IMG_H-1).

Optional Feature:
FG_COUNT_EN: when defined, adds output port fg_count [log2(IMG_W*IMG_H):0] (11 bits by default).
- Cleared on reset and on start accept.
- Increments on each handshake where pix_data=1.
- Saturates at the all-ones value; it cannot overflow for a legal image.
- Holds its value after done until the next start.
When undefined, the port and the counter are absent and all other behaviour is identical.

Decomposition:
Package cle_pkg holds:
- IMG_W and IMG_H constants
- coordinate width constants (log2 values)
- the state enum {IDLE, FETCH, STREAM, FLUSH}
- a packed neighbour struct {ul, u, ur, l}
One sub-module, cle_line_buf, holds lb and ul_save. It has write enable, x, y and pixel inputs, and produces the four neighbour outputs.

Test Plan:
- All-zero ROM, pix_ready=1 -> 1024 consecutive valid cycles; every pix_data and nb_* is 0; pix_last at (31,31); done 1 cycle after; first pix_valid 2 cycles after start.
- ROM addr 5 = 8'h80, all else 0, MSB_FIRST=1 -> only (x=8,y=1) is 1. Required neighbours:
  - (9,1): nb_l=1.
  - (7,2): nb_ur=1.
  - (8,2): nb_u=1.
  - (9,2): nb_ul=1.
  - Every other neighbour is 0.
- All 8'hFF image with random pix_ready (~50%) -> outputs stable while stalled; x/y sequence is strictly raster; row 0 nb_u/nb_ul/nb_ur=0; column 0 nb_l/nb_ul=0; FG_COUNT_EN build gives fg_count=11'h400.
- Checkerboard (even rows 8'hAA, odd rows 8'h55) -> each pixel's nb_u equals !pix_data for y>0; no bubble at byte or row boundaries with pix_ready=1.
- reset asserted at pixel 300 -> next cycle all outputs 0, no done. A following start streams the full frame again from (0,0) with the line buffer cleared.
- start pulsed repeatedly during STREAM -> ignored; exactly one done; rom_a ends at 127.

Source files
------------

// File: rtl/cle_pkg.sv
// cle_pkg: image geometry, coordinate widths and shared types for the labeling engine front end.
package cle_pkg;
    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ROM_AW = 7;
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);
    localparam int CW     = $clog2(IMG_W * IMG_H);
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FLUSH} state_e;
    typedef struct packed {
        logic ul;
        logic u;
        logic ur;
        logic l;
    } nb_t;
endpackage

// File: rtl/cle_line_buf.sv
// cle_line_buf: one-row pixel history producing the four causal neighbours of the current pixel.
module cle_line_buf
    import cle_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic          pix_i,
    output logic [3:0]    nb_o
);
    logic [IMG_W-1:0] lb_q;
    logic             ul_q;
    logic [XW-1:0]    xp, xm;
    logic             top_ok, left_ok, right_ok;
    assign xp       = x_i + 1'b1;
    assign xm       = x_i - 1'b1;
    assign top_ok   = y_i != '0;
    assign left_ok  = x_i != '0;
    assign right_ok = x_i != XW'(IMG_W - 1);
    // lb holds the previous row at and right of x, and the current row left of x
    always_ff @(posedge clk) begin
        if (reset) begin
            lb_q <= '0;
            ul_q <= 1'b0;
        end else if (we_i) begin
            ul_q     <= lb_q[x_i];
            lb_q[x_i] <= pix_i;
        end
    end
    assign nb_o = nb_t'{
        ul: ul_q & top_ok & left_ok,
        u:  lb_q[x_i] & top_ok,
        ur: lb_q[xp] & top_ok & right_ok,
        l:  lb_q[xm] & left_ok
    };
endmodule

// File: rtl/cle_pixel_streamer.sv
// cle_pixel_streamer: streams a packed binary image from a synchronous ROM as raster pixels with causal neighbours.
// Defining FG_COUNT_EN adds fg_count, a saturating count of foreground pixels accepted in the current frame.
module cle_pixel_streamer
    import cle_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_a,
    input  logic [7:0]        rom_q,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              nb_ul,
    output logic              nb_u,
    output logic              nb_ur,
    output logic              nb_l,
    output logic              pix_last,
    output logic              busy,
    output logic              done
`ifdef FG_COUNT_EN
    ,
    output logic [CW:0]       fg_count
`endif
);
    localparam logic [ROM_AW-1:0] ROM_LAST = '1;
    state_e            state_q;
    logic [ROM_AW-1:0] rom_a_q;
    logic [7:0]        cur_q, nxt_q;
    logic              nxt_v_q, fresh_q, wait_q, valid_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic              hs, last, byte_end, pix_bit;
    nb_t               nb;
    assign hs       = valid_q && pix_ready;
    assign last     = x_q == XW'(IMG_W - 1) && y_q == YW'(IMG_H - 1);
    assign byte_end = &x_q[2:0];
    assign pix_bit  = MSB_FIRST ? cur_q[~x_q[2:0]] : cur_q[x_q[2:0]];
    // fresh_q marks the cycle right after an address change, when rom_q is still stale
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rom_a_q <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            nxt_v_q <= 1'b0;
            fresh_q <= 1'b0;
            wait_q  <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            fresh_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= FETCH;
                    rom_a_q <= '0;
                    wait_q  <= 1'b0;
                    x_q     <= '0;
                    y_q     <= '0;
                end
                FETCH: begin
                    wait_q <= 1'b1;
                    if (wait_q) begin
                        cur_q   <= rom_q;
                        valid_q <= 1'b1;
                        rom_a_q <= rom_a_q + 1'b1;
                        nxt_v_q <= 1'b0;
                        fresh_q <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (!nxt_v_q && !fresh_q) begin
                        nxt_q   <= rom_q;
                        nxt_v_q <= 1'b1;
                    end
                    if (hs) begin
                        x_q <= x_q + 1'b1;
                        if (x_q == XW'(IMG_W - 1)) y_q <= y_q + 1'b1;
                        if (last) begin
                            valid_q <= 1'b0;
                            state_q <= FLUSH;
                        end else if (byte_end) begin
                            cur_q <= nxt_q;
                            if (rom_a_q != ROM_LAST) begin
                                rom_a_q <= rom_a_q + 1'b1;
                                nxt_v_q <= 1'b0;
                                fresh_q <= 1'b1;
                            end
                        end
                    end
                end
                FLUSH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    cle_line_buf u_lb (
        .clk   (clk),
        .reset (reset),
        .we_i  (hs),
        .x_i   (x_q),
        .y_i   (y_q),
        .pix_i (pix_bit),
        .nb_o  (nb)
    );
`ifdef FG_COUNT_EN
    logic [CW:0] fg_q;
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && start)) fg_q <= '0;
        else if (hs && pix_bit && !(&fg_q)) fg_q <= fg_q + 1'b1;
    end
    assign fg_count = fg_q;
`endif
    assign rom_a     = rom_a_q;
    assign pix_valid = valid_q;
    assign pix_data  = valid_q & pix_bit;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign nb_ul     = valid_q & nb.ul;
    assign nb_u      = valid_q & nb.u;
    assign nb_ur     = valid_q & nb.ur;
    assign nb_l      = valid_q & nb.l;
    assign pix_last  = valid_q & last;
    assign busy      = state_q != IDLE;
    assign done      = state_q == FLUSH;
endmodule

// File: tb/tb_cle_pixel_streamer.sv
// tb_cle_pixel_streamer: directed frame table plus reset-abort and start-spam sequences against an image-level neighbour model.
module tb_cle_pixel_streamer;
    logic       clk = 1'b0;
    logic       reset, start, pix_ready;
    logic [6:0] rom_a;
    logic [7:0] rom_q;
    logic       pix_valid, pix_data, nb_ul, nb_u, nb_ur, nb_l, pix_last, busy, done;
    logic [4:0] pix_x, pix_y;
`ifdef FG_COUNT_EN
    logic [10:0] fg_count;
`endif
    logic [7:0] mem [0:127];
    logic [4:0] rec [0:1023];
    int checks = 0, failures = 0;
    int hs_cnt, bubbles, stall_err, order_err, model_err, last_err, done_cnt, done_k, last_k, lat, fg_obs;

    typedef struct {
        int kind;
        int rmode;
        int fg;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) rom_q <= mem[rom_a];

    cle_pixel_streamer dut (
`ifdef FG_COUNT_EN
        .fg_count  (fg_count),
`endif
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rom_a     (rom_a),
        .rom_q     (rom_q),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .nb_ul     (nb_ul),
        .nb_u      (nb_u),
        .nb_ur     (nb_ur),
        .nb_l      (nb_l),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic img(input int x, input int y);
        logic [7:0] b;
        if (x < 0 || x > 31 || y < 0 || y > 31) return 1'b0;
        b = mem[y * 4 + x / 8];
        return b[7 - x % 8];
    endfunction

    // {data, ul, u, ur, l} taken straight from the image
    function automatic logic [4:0] exp_px(input int x, input int y);
        return {img(x, y), img(x - 1, y - 1), img(x, y - 1), img(x + 1, y - 1), img(x - 1, y)};
    endfunction

    task automatic load(input int kind);
        for (int a = 0; a < 128; a++)
            mem[a] = kind == 0 ? 8'h00 : kind == 1 ? (a == 5 ? 8'h80 : 8'h00) :
                     kind == 2 ? 8'hFF : ((a / 4) % 2 == 0 ? 8'hAA : 8'h55);
    endtask

    task automatic run_frame(input int rmode, input bit spam, input int abort_at);
        logic [16:0] snap, cur;
        bit prev_stall, rdy;
        int first;
        prev_stall = 1'b0; first = -1; snap = '0;
        hs_cnt = 0; bubbles = 0; stall_err = 0; order_err = 0; model_err = 0;
        last_err = 0; done_cnt = 0; done_k = -1; last_k = -1; fg_obs = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            cur = {pix_valid, pix_data, nb_ul, nb_u, nb_ur, nb_l, pix_last, pix_x, pix_y};
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (pix_valid && first < 0) first = k;
            if (prev_stall && cur !== snap) stall_err++;
            if (first >= 0 && hs_cnt < 1024 && !pix_valid) bubbles++;
            if (pix_valid && (pix_last !== (pix_x == 5'd31 && pix_y == 5'd31))) last_err++;
            if (hs_cnt == abort_at) break;
            if (done_k >= 0 && k > done_k + 3) break;
            rdy = rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            pix_ready = rdy;
            start = spam && hs_cnt < 1000 && k % 37 == 0;
            if (pix_valid && rdy) begin
                if (pix_x != 5'(hs_cnt % 32) || pix_y != 5'(hs_cnt / 32)) order_err++;
                rec[hs_cnt] = {pix_data, nb_ul, nb_u, nb_ur, nb_l};
                if (rec[hs_cnt] !== exp_px(hs_cnt % 32, hs_cnt / 32)) model_err++;
                fg_obs += int'(pix_data);
                hs_cnt++;
                if (hs_cnt == 1024) last_k = k;
            end
            prev_stall = pix_valid && !rdy;
            snap = cur;
            @(negedge clk);
        end
        start = 1'b0;
        pix_ready = 1'b1;
        lat = first;
    endtask

    task automatic frame_checks(input int exp_fg);
        chk("handshakes", hs_cnt, 1024);
        chk("first_valid_latency", lat, 2);
        chk("bubbles", bubbles, 0);
        chk("stall_stability", stall_err, 0);
        chk("raster_order", order_err, 0);
        chk("pixel_neighbour_model", model_err, 0);
        chk("pix_last_position", last_err, 0);
        chk("foreground_pixels", fg_obs, exp_fg);
        chk("done_pulses", done_cnt, 1);
        chk("done_after_last", done_k, last_k + 1);
        chk("rom_a_end", int'(rom_a), 127);
        chk("busy_after_frame", int'(busy), 0);
`ifdef FG_COUNT_EN
        chk("fg_count", int'(fg_count), exp_fg);
`endif
    endtask

    initial begin
        vec_t tbl [5];
        int n;
        tbl = '{'{0, 0, 0}, '{1, 0, 1}, '{2, 1, 1024}, '{3, 0, 512}, '{3, 1, 512}};
        reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
        load(0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({rom_a, pix_valid, pix_data, nb_ul, nb_u, nb_ur, nb_l,
                                   pix_last, busy, done, pix_x, pix_y}), 0);
        reset = 1'b0;
        @(negedge clk);
        foreach (tbl[i]) begin
            load(tbl[i].kind);
            run_frame(tbl[i].rmode, 1'b0, -1);
            frame_checks(tbl[i].fg);
            if (tbl[i].kind == 1) begin
                chk("single_8_1", int'(rec[32 + 8]), 5'b10000);
                chk("single_nb_l_9_1", int'(rec[32 + 9]), 5'b00001);
                chk("single_nb_ur_7_2", int'(rec[64 + 7]), 5'b00010);
                chk("single_nb_u_8_2", int'(rec[64 + 8]), 5'b00100);
                chk("single_nb_ul_9_2", int'(rec[64 + 9]), 5'b01000);
                n = 0;
                for (int p = 0; p < 1024; p++) n += int'(|rec[p][3:0]);
                chk("single_nb_total", n, 4);
            end
            if (tbl[i].kind == 2) begin
                n = 0;
                for (int x = 0; x < 32; x++) n += int'(|rec[x][3:1]);
                chk("ff_row0_upper_nb", n, 0);
                n = 0;
                for (int y = 0; y < 32; y++) n += int'(rec[y * 32][3] | rec[y * 32][0]);
                chk("ff_col0_left_nb", n, 0);
                chk("ff_interior_5_5", int'(rec[5 * 32 + 5]), 5'b11111);
                chk("ff_right_edge_31_5", int'(rec[5 * 32 + 31]), 5'b11101);
            end
            if (tbl[i].kind == 3) begin
                n = 0;
                for (int p = 32; p < 1024; p++) n += int'(rec[p][2] == rec[p][4]);
                chk("checker_nb_u_inverted", n, 0);
            end
        end
        load(2);
        run_frame(0, 1'b0, 300);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", int'({rom_a, pix_valid, pix_data, nb_ul, nb_u, nb_ur, nb_l,
                                        pix_last, busy, done, pix_x, pix_y}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done", int'(done), 0);
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        load(1);
        run_frame(1, 1'b0, -1);
        frame_checks(1);
        load(3);
        run_frame(0, 1'b1, -1);
        frame_checks(512);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
